// File: rtl/decode_pipe_stage_if.sv
// Handshake and data bundle between fetch, the decode stage and execute.
// The master modport is the environment (fetch/execute/write-back side);
// the slave modport is the decode stage itself.
interface decode_pipe_stage_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RA_W  = $clog2(NREGS)
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [1:0]      op_a_sel;
  logic            op_b_sel;
  logic            wb_en;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_ld_pending;
  logic [RA_W-1:0] ex_ld_rd;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_op_a;
  logic [XLEN-1:0] out_op_b;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [RA_W-1:0] out_rd;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, op_a_sel, op_b_sel,
    output wb_en, wb_rd, wb_data, ex_ld_pending, ex_ld_rd, flush, out_ready,
    input  in_ready, out_valid, out_op_a, out_op_b, out_rs2_data, out_imm, out_rd, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, op_a_sel, op_b_sel,
    input  wb_en, wb_rd, wb_data, ex_ld_pending, ex_ld_rd, flush, out_ready,
    output in_ready, out_valid, out_op_a, out_op_b, out_rs2_data, out_imm, out_rd, out_pc
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// Registered decode stage: field/immediate decode, register file with
// write-back bypass, operand selection, load-use stall and a valid/ready
// output register with flush.
module decode_pipe_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RA_W  = $clog2(NREGS)
) (
  input logic               clk,
  input logic               rst_n,
  decode_pipe_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [XLEN-1:0] r_regs [NREGS];

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_op_a;
  logic [XLEN-1:0] r_out_op_b;
  logic [XLEN-1:0] r_out_rs2_data;
  logic [XLEN-1:0] r_out_imm;
  logic [RA_W-1:0] r_out_rd;
  logic [XLEN-1:0] r_out_pc;

  logic [RA_W-1:0] w_rs1;
  logic [RA_W-1:0] w_rs2;
  logic [RA_W-1:0] w_rd;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_wb_write;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic            w_hazard;
  logic            w_advance;
  logic            w_in_ready;
  logic            w_accept;

  assign w_rs1 = bus.in_instr[15 +: RA_W];
  assign w_rs2 = bus.in_instr[20 +: RA_W];
  assign w_rd  = bus.in_instr[7 +: RA_W];

  // Immediate decode to a 32-bit value, sign-extended from bit 31.
  always_comb begin
    w_imm32 = 32'h0000_0000;
    case (bus.in_instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      OPC_STORE:
        w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      OPC_BRANCH:
        w_imm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                   bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        w_imm32 = {bus.in_instr[31:12], 12'h000};
      OPC_JAL:
        w_imm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                   bus.in_instr[20], bus.in_instr[30:21], 1'b0};
      default:
        w_imm32 = 32'h0000_0000;
    endcase
  end

  // Widen to XLEN keeping the sign of the 32-bit immediate.
  assign w_imm = XLEN'($signed(w_imm32));

  // Writes to x0 are dropped so it keeps reading as zero.
  assign w_wb_write = bus.wb_en & (bus.wb_rd != {RA_W{1'b0}});

  // Operand reads with same-cycle write-back bypass.
  always_comb begin
    if (w_wb_write && (bus.wb_rd == w_rs1)) begin
      w_rs1_data = bus.wb_data;
    end else if (w_rs1 == {RA_W{1'b0}}) begin
      w_rs1_data = {XLEN{1'b0}};
    end else begin
      w_rs1_data = r_regs[w_rs1];
    end
    if (w_wb_write && (bus.wb_rd == w_rs2)) begin
      w_rs2_data = bus.wb_data;
    end else if (w_rs2 == {RA_W{1'b0}}) begin
      w_rs2_data = {XLEN{1'b0}};
    end else begin
      w_rs2_data = r_regs[w_rs2];
    end
  end

  // Operand A/B selection; PC+4 wraps naturally at XLEN bits.
  always_comb begin
    case (bus.op_a_sel)
      2'b00:   w_op_a = w_rs1_data;
      2'b01:   w_op_a = bus.in_pc;
      2'b10:   w_op_a = bus.in_pc + XLEN'(32'd4);
      2'b11:   w_op_a = {XLEN{1'b0}};
      default: w_op_a = {XLEN{1'b0}};
    endcase
    if (bus.op_b_sel) begin
      w_op_b = w_imm;
    end else begin
      w_op_b = w_rs2_data;
    end
  end

  // Load-use check looks at both source fields whatever the operand selects.
  assign w_hazard   = bus.in_valid & bus.ex_ld_pending & (bus.ex_ld_rd != {RA_W{1'b0}}) &
                      ((bus.ex_ld_rd == w_rs1) | (bus.ex_ld_rd == w_rs2));
  assign w_advance  = bus.out_ready | ~r_out_valid;
  assign w_in_ready = w_advance & ~w_hazard & ~bus.flush;
  assign w_accept   = bus.in_valid & w_in_ready;

  // Register file storage; cleared on reset, x0 never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else if (w_wb_write) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Output pipeline register: flush > accept > bubble > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_op_a     <= {XLEN{1'b0}};
      r_out_op_b     <= {XLEN{1'b0}};
      r_out_rs2_data <= {XLEN{1'b0}};
      r_out_imm      <= {XLEN{1'b0}};
      r_out_rd       <= {RA_W{1'b0}};
      r_out_pc       <= {XLEN{1'b0}};
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_op_a     <= w_op_a;
      r_out_op_b     <= w_op_b;
      r_out_rs2_data <= w_rs2_data;
      r_out_imm      <= w_imm;
      r_out_rd       <= w_rd;
      r_out_pc       <= bus.in_pc;
    end else if (w_advance) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_op_a     = r_out_op_a;
  assign bus.out_op_b     = r_out_op_b;
  assign bus.out_rs2_data = r_out_rs2_data;
  assign bus.out_imm      = r_out_imm;
  assign bus.out_rd       = r_out_rd;
  assign bus.out_pc       = r_out_pc;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Self-checking bench for decode_pipe_stage: directed scenarios plus a
// randomized run, all compared against a behavioural model of the stage.
module tb_decode_pipe_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  decode_pipe_stage_if #(.XLEN(32), .NREGS(32)) bus ();

  decode_pipe_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_op_a, m_op_b, m_rs2, m_imm, m_pc;
  logic [4:0]  m_rd;

  // Immediate value computed arithmetically from the format rules.
  function automatic logic [31:0] model_imm(input logic [31:0] ins);
    int v;
    int sgn;
    sgn = int'(ins[31]);
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: v = int'(ins[31:20]) - sgn * 4096;
      7'h23: v = int'(ins[31:25]) * 32 + int'(ins[11:7]) - sgn * 4096;
      7'h63: v = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
                 int'(ins[11:8]) * 2 - sgn * 8192;
      7'h37, 7'h17: v = int'(ins & 32'hFFFF_F000);
      7'h6F: v = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 +
                 int'(ins[30:21]) * 2 - sgn * 2097152;
      default: v = 0;
    endcase
    return v;
  endfunction

  // Register read as seen by decode, including write-back forwarding.
  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
    return m_regs[idx];
  endfunction

  function automatic logic model_ready();
    logic [4:0] s1, s2;
    logic hz;
    s1 = bus.in_instr[19:15];
    s2 = bus.in_instr[24:20];
    hz = bus.in_valid && bus.ex_ld_pending && bus.ex_ld_rd != 5'd0 &&
         (bus.ex_ld_rd == s1 || bus.ex_ld_rd == s2);
    return (bus.out_ready || !m_valid) && !hz && !bus.flush;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 1'b0; m_op_a = 32'h0; m_op_b = 32'h0; m_rs2 = 32'h0;
    m_imm = 32'h0; m_rd = 5'd0; m_pc = 32'h0;
  endtask

  // Advance model by one edge using the current inputs, then clock the DUT.
  task automatic cycle();
    logic rdy;
    rdy = model_ready();
    if (bus.flush) begin
      m_valid = 1'b0;
    end else if (bus.in_valid && rdy) begin
      case (bus.op_a_sel)
        2'd0: m_op_a = model_read(bus.in_instr[19:15]);
        2'd1: m_op_a = bus.in_pc;
        2'd2: m_op_a = bus.in_pc + 32'd4;
        default: m_op_a = 32'h0;
      endcase
      m_rs2   = model_read(bus.in_instr[24:20]);
      m_imm   = model_imm(bus.in_instr);
      m_op_b  = bus.op_b_sel ? m_imm : m_rs2;
      m_rd    = bus.in_instr[11:7];
      m_pc    = bus.in_pc;
      m_valid = 1'b1;
    end else if (bus.out_ready || !m_valid) begin
      m_valid = 1'b0;
    end
    if (bus.wb_en && bus.wb_rd != 5'd0) m_regs[bus.wb_rd] = bus.wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0;
    bus.op_a_sel = 2'd0; bus.op_b_sel = 1'b0; bus.wb_en = 1'b0;
    bus.wb_rd = 5'd0; bus.wb_data = 32'h0; bus.ex_ld_pending = 1'b0;
    bus.ex_ld_rd = 5'd0; bus.flush = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [1:0] asel, input logic bsel);
    bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_pc = pc;
    bus.op_a_sel = asel; bus.op_b_sel = bsel;
  endtask

  task automatic test_reset_bypass();
    idle();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h55;
    offer(32'h0000_0113, 32'h40, 2'd1, 1'b0);
    cycle();
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_op_a, bus.out_op_b, bus.out_rs2_data, bus.out_imm,
         bus.out_rd, bus.out_pc} !== {1'b0, 128'h0, 5'd0, 32'h0}) begin
      failures++;
      $display("FAIL reset_outputs valid=%b a=%h b=%h rs2=%h imm=%h rd=%0d pc=%h required all zero",
               bus.out_valid, bus.out_op_a, bus.out_op_b, bus.out_rs2_data, bus.out_imm,
               bus.out_rd, bus.out_pc);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_hold_valid got=%b exp=0", bus.out_valid);
    end
    rst_n = 1'b1;
    // add x1,x5,x0 with no write-back: x5 must have been cleared by reset.
    offer(32'h0002_80B3, 32'h80, 2'd0, 1'b0);
    cycle();
    checks++;
    if (bus.out_op_a !== 32'h0 || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL reset_regclear op_a=%h valid=%b exp 0/1", bus.out_op_a, bus.out_valid);
    end
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h0000_00AA;
    cycle();
    checks++;
    if (bus.out_op_a !== 32'hAA || bus.out_op_b !== 32'h0 || bus.out_rd !== 5'd1 ||
        bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bypass op_a=%h op_b=%h rd=%0d valid=%b exp AA/0/1/1",
               bus.out_op_a, bus.out_op_b, bus.out_rd, bus.out_valid);
    end
    idle();
  endtask

  task automatic test_x0();
    idle();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
    offer(32'h0000_00B3, 32'h0, 2'd0, 1'b0);
    cycle();
    checks++;
    if (bus.out_op_a !== 32'h0) begin
      failures++; $display("FAIL x0_same_cycle op_a=%h exp=0", bus.out_op_a);
    end
    bus.wb_en = 1'b0;
    cycle();
    checks++;
    if (bus.out_op_a !== 32'h0) begin
      failures++; $display("FAIL x0_after_write op_a=%h exp=0", bus.out_op_a);
    end
    idle();
  endtask

  task automatic test_imm();
    logic [31:0] ins [4] = '{32'hFFF0_0093, 32'hFE00_0EE3, 32'h1234_50B7, 32'h0000_0013};
    logic [31:0] pcs [4] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC};
    logic [1:0]  asl [4] = '{2'd3, 2'd3, 2'd3, 2'd2};
    int          fld [4] = '{1, 2, 2, 0};
    logic [31:0] exv [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h1234_5000, 32'h0};
    logic [31:0] got;
    idle();
    for (int i = 0; i < 4; i++) begin
      offer(ins[i], pcs[i], asl[i], 1'b1);
      cycle();
      got = (fld[i] == 0) ? bus.out_op_a : (fld[i] == 1) ? bus.out_op_b : bus.out_imm;
      checks++;
      if (got !== exv[i] || bus.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL imm_case%0d got=%h exp=%h valid=%b", i, got, exv[i], bus.out_valid);
      end
    end
    idle();
  endtask

  task automatic test_load_use();
    idle();
    offer(32'h0000_0013, 32'h200, 2'd1, 1'b0);
    cycle();
    bus.ex_ld_pending = 1'b1; bus.ex_ld_rd = 5'd3;
    offer(32'h0030_0233, 32'h204, 2'd1, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL loaduse_ready got=%b exp=0", bus.in_ready);
    end
    cycle();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h200) begin
      failures++; $display("FAIL loaduse_bubble valid=%b pc=%h exp 0/200", bus.out_valid, bus.out_pc);
    end
    bus.ex_ld_pending = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL loaduse_release_ready got=%b exp=1", bus.in_ready);
    end
    cycle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd4 || bus.out_pc !== 32'h204) begin
      failures++; $display("FAIL loaduse_accept valid=%b rd=%0d pc=%h exp 1/4/204",
                           bus.out_valid, bus.out_rd, bus.out_pc);
    end
    bus.ex_ld_pending = 1'b1; bus.ex_ld_rd = 5'd0;
    offer(32'h0010_0293, 32'h208, 2'd1, 1'b1);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL loaduse_x0_ready got=%b exp=1", bus.in_ready);
    end
    cycle();
    bus.out_ready = 1'b0; bus.ex_ld_rd = 5'd3;
    offer(32'h0030_0233, 32'h20C, 2'd1, 1'b0);
    cycle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd5 || bus.out_pc !== 32'h208) begin
      failures++; $display("FAIL loaduse_stall_hold valid=%b rd=%0d pc=%h exp 1/5/208",
                           bus.out_valid, bus.out_rd, bus.out_pc);
    end
    idle();
  endtask

  task automatic test_backpressure();
    idle();
    offer(32'h0000_0013, 32'h100, 2'd1, 1'b0);
    cycle();
    bus.out_ready = 1'b0;
    offer(32'h0000_0013, 32'h104, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_ready cyc%0d got=%b exp=0", i, bus.in_ready);
      end
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_op_a !== 32'h100) begin
        failures++; $display("FAIL bp_hold cyc%0d valid=%b pc=%h op_a=%h exp 1/100/100",
                             i, bus.out_valid, bus.out_pc, bus.out_op_a);
      end
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'h0000_0013 | (32'(i + 1) << 7), 32'h104 + 32'(4 * i), 2'd1, 1'b0);
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h104 + 32'(4 * i) ||
          bus.out_rd !== 5'(i + 1)) begin
        failures++; $display("FAIL bp_stream%0d valid=%b pc=%h rd=%0d exp pc=%h rd=%0d", i,
                             bus.out_valid, bus.out_pc, bus.out_rd, 32'h104 + 32'(4 * i), i + 1);
      end
    end
    idle();
  endtask

  task automatic test_flush();
    idle();
    offer(32'h0000_0013, 32'h300, 2'd1, 1'b0);
    cycle();
    bus.flush = 1'b1;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h0000_1234;
    offer(32'h0003_8113, 32'h304, 2'd0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_ready got=%b exp=0", bus.in_ready);
    end
    cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid);
    end
    bus.flush = 1'b0; bus.wb_en = 1'b0;
    cycle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_op_a !== 32'h1234 || bus.out_pc !== 32'h304) begin
      failures++; $display("FAIL flush_wb_visible valid=%b op_a=%h pc=%h exp 1/1234/304",
                           bus.out_valid, bus.out_op_a, bus.out_pc);
    end
    idle();
  endtask

  task automatic test_random();
    logic [6:0]  ops [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    logic [31:0] r;
    logic        rdy;
    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      r[6:0]   = ops[$urandom_range(0, 9)];
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      bus.in_instr      = r;
      bus.in_valid      = 1'($urandom_range(0, 3) != 0);
      bus.in_pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
      bus.op_a_sel      = 2'($urandom_range(0, 3));
      bus.op_b_sel      = 1'($urandom_range(0, 1));
      bus.wb_en         = 1'($urandom_range(0, 1));
      bus.wb_rd         = 5'($urandom_range(0, 7));
      bus.wb_data       = $urandom();
      bus.ex_ld_pending = 1'($urandom_range(0, 2) == 0);
      bus.ex_ld_rd      = 5'($urandom_range(0, 7));
      bus.flush         = 1'($urandom_range(0, 9) == 0);
      bus.out_ready     = 1'($urandom_range(0, 9) < 7);
      #1;
      rdy = model_ready();
      checks++;
      if (bus.in_ready !== rdy) begin
        failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, bus.in_ready, rdy);
      end
      cycle();
      checks++;
      if (bus.out_valid !== m_valid || bus.out_op_a !== m_op_a || bus.out_op_b !== m_op_b ||
          bus.out_rs2_data !== m_rs2 || bus.out_imm !== m_imm || bus.out_rd !== m_rd ||
          bus.out_pc !== m_pc) begin
        failures++;
        $display("FAIL rand_out c=%0d got v=%b a=%h b=%h s=%h i=%h rd=%0d pc=%h exp v=%b a=%h b=%h s=%h i=%h rd=%0d pc=%h",
                 c, bus.out_valid, bus.out_op_a, bus.out_op_b, bus.out_rs2_data, bus.out_imm,
                 bus.out_rd, bus.out_pc, m_valid, m_op_a, m_op_b, m_rs2, m_imm, m_rd, m_pc);
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset_bypass();
    test_x0();
    test_imm();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Registered instruction-decode stage with an integrated register file, parametrised in datapath width and register count. It sits between fetch and execute. It decodes register indices and the sign-extended immediate, reads operands with same-cycle write-back bypass, and selects operands A/B. It also detects load-use hazards, and holds results in a valid/ready pipeline register with flush support.

## Interface
- XLEN, 32, datapath width; legal values ≥ 32.
- NREGS, 32, number of architectural registers; must be a power of two and ≤ 32.
- RA_W, $clog2(NREGS), register index width. Instruction fields are truncated to RA_W bits.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage accepts the offered instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- op_a_sel  in  2  operand A select: 00 rs1 data, 01 PC, 10 PC+4, 11 zero.
- op_b_sel  in  1  operand B select: 1 immediate, 0 rs2 data.
- wb_en  in  1  write-back enable.
- wb_rd  in  RA_W  write-back destination.
- wb_data  in  XLEN  write-back data.
- ex_ld_pending  in  1  execute stage holds a valid load.
- ex_ld_rd  in  RA_W  destination of that load.
- flush  in  1  kill the contents of the stage and the offered instruction.
- out_valid  out  1  output register holds a valid decoded instruction.
- out_ready  in  1  downstream accepts the output.
- out_op_a, out_op_b  out  XLEN  selected operands.
- out_rs2_data  out  XLEN  rs2 value (store data), independent of op_b_sel.
- out_imm  out  XLEN  decoded immediate.
- out_rd  out  RA_W  destination index.
- out_pc  out  XLEN  PC of the held instruction.

## Operation
- Field decode: rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7]. Each is truncated to RA_W.
- Immediate decode by opcode instr[6:0], sign-extended from instr[31] to XLEN:
  - I-type for 0010011, 0000011, 1100111.
  - S-type for 0100011.
  - B-type for 1100011 (bit 0 = 0).
  - U-type for 0110111, 0010111 (low 12 bits = 0).
  - J-type for 1101111 (bit 0 = 0).
  - All other opcodes produce 0.
- Register file: NREGS × XLEN.
  - Register 0 reads as 0 and ignores writes.
  - Writes occur at the rising edge when wb_en is high.
  - All entries clear to 0 on reset.
- Bypass: if wb_en is high, wb_rd ≠ 0 and wb_rd equals the read index, the read returns wb_data in the same cycle.
- Load-use hazard: hazard = in_valid & ex_ld_pending & ex_ld_rd ≠ 0 & (ex_ld_rd == rs1 | ex_ld_rd == rs2). The check applies to rs1/rs2 regardless of op_a_sel/op_b_sel.
- advance = out_ready | ~out_valid.
- in_ready = advance & ~hazard & ~flush.
- Output register update, evaluated in priority order at each rising edge:
  - If flush: out_valid ← 0.
  - Else if in_valid & in_ready: load all outputs and set out_valid ← 1.
  - Else if advance: out_valid ← 0 (bubble). During a hazard, the data fields hold their previous values.
  - Else (stalled downstream): hold everything.
- PC+4 is computed modulo 2^XLEN.

## Timing
- Latency: 1 cycle from the accept edge to out_valid.
- Throughput: 1 instruction/cycle when out_ready is held high and there is no hazard.
- in_ready is combinational from out_valid, out_ready, in_valid, ex_ld_*, in_instr and flush. There is no combinational path from in_ready back to in_valid.
- Outputs are registered. While out_valid & ~out_ready, the outputs stay stable.
- Reset (async, any time, including mid-stall):
  - out_valid = 0.
  - out_op_a, out_op_b, out_rs2_data, out_imm, out_pc all = 0.
  - out_rd = 0.
  - All registers = 0.
- Reset release takes effect at the next edge. in_ready may be 1 in the first cycle after release.
- Simultaneous write-back and read of the same register: the new value is used (bypass).
- flush together with in_valid: the offered instruction is not accepted and out_valid is 0 next cycle. A register-file write in the same cycle still completes.
- Hazard and a downstream stall in the same cycle: the output is held (not bubbled).

## Test plan
- Reset then bypass:
  - Stimulus: reset low mid-run, then release. Write x5 = 0x0000_00AA with wb_en, and in the same cycle offer `add x1,x5,x0` with op_a_sel = 00, op_b_sel = 0.
  - Required: during reset all outputs are 0. Next cycle out_op_a = 0xAA, out_op_b = 0, out_rd = 1, out_valid = 1.
- x0 protection:
  - Stimulus: wb_en, wb_rd = 0, wb_data = 0xFFFF_FFFF, then read x0.
  - Required: operand A = 0.
- Immediates (op_b_sel = 1):
  - Instruction 0xFFF00093 (addi x1,x0,-1) → out_op_b = 0xFFFF_FFFF.
  - B-type 0xFE000EE3 → out_imm = 0xFFFF_FFFC.
  - LUI 0x123450B7 → out_imm = 0x1234_5000.
  - op_a_sel = 10 with pc = 0xFFFF_FFFC → out_op_a = 0.
- Load-use:
  - Stimulus: ex_ld_pending = 1, ex_ld_rd = 3, offered instruction reads x3.
  - Required: in_ready = 0 for that cycle and a bubble (out_valid = 0) follows. After ex_ld_pending drops, the instruction is accepted next cycle.
  - Same stimulus with ex_ld_rd = 0: no stall.
- Backpressure:
  - Stimulus: out_ready = 0 for 3 cycles with in_valid held.
  - Required: outputs stable, in_ready = 0. After release, back-to-back instructions stream one per cycle in order.
- Flush:
  - Stimulus: assert flush while out_valid = 1 and in_valid = 1.
  - Required: out_valid = 0 next cycle, offered instruction not accepted, and a write-back in that cycle is visible on a subsequent read.
